alu_req_scheduler: RTL and testbench

//  Shares the single tiny 4-bit ALU (incl. its internal register file) between NUM_REQ requesters.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_rr_arbiter.sv | 42 ++++
 rtl/alu_req_scheduler.sv | 142 ++++++++++++++
 tb/tb_alu_req_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: opcode encodings,
// flag bit positions inside the ALU uo_out byte, scheduler FSM states
// and the opcode legality check.
package alu_pkg;

    localparam logic [3:0] OP_ADD       = 4'h0;
    localparam logic [3:0] OP_SUB       = 4'h1;
    localparam logic [3:0] OP_AND       = 4'h2;
    localparam logic [3:0] OP_OR        = 4'h3;
    localparam logic [3:0] OP_XOR       = 4'h4;
    localparam logic [3:0] OP_SHL       = 4'h5;
    localparam logic [3:0] OP_SHR       = 4'h6;
    localparam logic [3:0] OP_PASS_B    = 4'h7;
    localparam logic [3:0] OP_REG_WRITE = 4'h8;
    localparam logic [3:0] OP_REG_READ  = 4'h9;
    localparam logic [3:0] OP_ADD_REG   = 4'hA;
    localparam logic [3:0] OP_SUB_REG   = 4'hB;

    // Flag positions in uo_out / rsp_data: {Z,N,V,C,result[3:0]}
    localparam int unsigned FLAG_Z = 7;
    localparam int unsigned FLAG_N = 6;
    localparam int unsigned FLAG_V = 5;
    localparam int unsigned FLAG_C = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Legal opcodes are 0000-1011; 11xx is rejected.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op[3:2] != 2'b11);
    endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter.
//   req        in   NUM_REQ  request vector
//   ptr        in   ID_W     index of the last granted requester
//   grant      out  NUM_REQ  one-hot grant (zero when no request)
//   grant_idx  out  ID_W     index of the granted requester
//   grant_any  out  1        at least one request present
// Search begins at ptr+1 (wrapping) so the last winner has lowest priority.
module alu_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // (ptr + 1 + k) mod NUM_REQ; one conditional subtract suffices
            sum = {1'b0, ptr} + (ID_W+1)'(k + 1);
            if (sum >= (ID_W+1)'(NUM_REQ))
                sum = sum - (ID_W+1)'(NUM_REQ);
            idx = sum[ID_W-1:0];
            if (!grant_any && req[idx]) begin
                grant_any      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one 4-bit ALU between NUM_REQ requesters: round-robin grant,
// one operation in flight, ALU inputs held ALU_LAT cycles, result+flags
// returned on a valid/ready response channel.
//   clk, rst                    clock, async active-high reset
//   req_valid/req_ready         per-requester handshake (ready one-hot)
//   req_op/req_a/req_b          packed per-requester operands (4 bits each)
//   rsp_valid/rsp_ready         response handshake
//   rsp_id/rsp_data/rsp_err     owner, {Z,N,V,C,result}, illegal-op flag
//   busy                        high whenever not IDLE
//   alu_ui_in/alu_uio/alu_uo_out  ALU pins ({B,A}, {0,op}, result)
module alu_req_scheduler
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1,
    parameter int unsigned ALU_LAT = 2,
    parameter logic [3:0]  IDLE_OP = 4'b0111
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_op,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [7:0]           alu_ui_in,
    output logic [7:0]           alu_uio,
    input  logic [7:0]           alu_uo_out
);

    localparam int unsigned CNT_W = $clog2(ALU_LAT + 1);

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         op_q, a_q, b_q;

    logic [3:0] op_arr [NUM_REQ];
    logic [3:0] a_arr  [NUM_REQ];
    logic [3:0] b_arr  [NUM_REQ];
    logic [3:0] sel_op, sel_a, sel_b;
    logic       sel_legal;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_arr[g] = req_op[4*g +: 4];
        assign a_arr[g]  = req_a[4*g +: 4];
        assign b_arr[g]  = req_b[4*g +: 4];
    end

    assign sel_op    = op_arr[grant_idx];
    assign sel_a     = a_arr[grant_idx];
    assign sel_b     = b_arr[grant_idx];
    assign sel_legal = is_legal_op(sel_op);

    alu_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        unique case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    req_ready = grant;
                    // Illegal ops bypass the ALU entirely.
                    state_nxt = sel_legal ? ST_EXEC : ST_RESP;
                end
            end
            ST_EXEC: begin
                if (cnt == CNT_W'(1))
                    state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outside EXEC the ALU sees PASS_B with zero operands, which never
    // touches its register file.
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign alu_ui_in = (state == ST_EXEC) ? {b_q, a_q} : 8'h00;
    assign alu_uio   = (state == ST_EXEC) ? {4'b0000, op_q} : {4'b0000, IDLE_OP};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            cnt      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        op_q    <= sel_op;
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        rsp_id  <= grant_idx;
                        rr_ptr  <= grant_idx;
                        cnt     <= CNT_W'(ALU_LAT);
                        rsp_err <= ~sel_legal;
                        if (!sel_legal)
                            rsp_data <= '0;
                    end
                end
                ST_EXEC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        rsp_data <= alu_uo_out;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Self-checking bench for alu_req_scheduler with a behavioural 4-bit ALU
// (including its register file) attached to the ALU pins.
module tb_alu_req_scheduler;
    import alu_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;
    localparam int ALU_LAT = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_op, req_a, req_b;
    logic                 rsp_valid, rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [7:0]           rsp_data;
    logic                 rsp_err, busy;
    logic [7:0]           alu_ui_in, alu_uio, alu_uo_out;

    always #5 clk = ~clk;

    alu_req_scheduler #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .ALU_LAT (ALU_LAT),
        .IDLE_OP (4'b0111)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .alu_ui_in  (alu_ui_in),
        .alu_uio    (alu_uio),
        .alu_uo_out (alu_uo_out)
    );

    // ---------------- ALU behaviour ----------------
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic [3:0] rb);
        logic [4:0] s;
        logic [3:0] r;
        logic       c, v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD, OP_ADD_REG: begin
                logic [3:0] o;
                o = (op == OP_ADD) ? b : rb;
                s = {1'b0, a} + {1'b0, o};
                r = s[3:0]; c = s[4];
                v = (a[3] == o[3]) && (r[3] != a[3]);
            end
            OP_SUB, OP_SUB_REG: begin
                logic [3:0] o;
                o = (op == OP_SUB) ? b : rb;
                s = {1'b0, a} - {1'b0, o};
                r = s[3:0]; c = s[4];
                v = (a[3] != o[3]) && (r[3] != a[3]);
            end
            OP_AND:       r = a & b;
            OP_OR:        r = a | b;
            OP_XOR:       r = a ^ b;
            OP_SHL:       begin r = {a[2:0], 1'b0}; c = a[3]; end
            OP_SHR:       begin r = {1'b0, a[3:1]}; c = a[0]; end
            OP_PASS_B:    r = b;
            OP_REG_WRITE: r = a;
            OP_REG_READ:  r = rb;
            default:      r = '0;
        endcase
        return {(r == 4'h0), r[3], v, c, r};
    endfunction

    logic [3:0] alu_rf [16];
    logic [3:0] rf_exp [16];
    initial for (int i = 0; i < 16; i++) begin alu_rf[i] = '0; rf_exp[i] = '0; end

    always @(posedge clk)
        if (alu_uio[3:0] == OP_REG_WRITE) alu_rf[alu_ui_in[7:4]] <= alu_ui_in[3:0];

    assign alu_uo_out = alu_f(alu_uio[3:0], alu_ui_in[3:0], alu_ui_in[7:4], alu_rf[alu_ui_in[7:4]]);

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int         id;
        logic [7:0] data;
        int         err;
        int         lat;
        int         acc;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   cyc = 0;
    int   exp_ptr = 0;
    int   grant_cnt = 0;
    int   rsp_cnt = 0;
    logic prev_rv = 1'b0;
    logic [7:0] last_data;
    int   last_id, last_err;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: reference arbiter, scoreboard push on accept, pop on response.
    int         g, c;
    logic [3:0] mop, ma, mb;
    exp_t       ne, e;
    always @(negedge clk) begin
        if (rst) begin
            prev_rv = 1'b0;
        end else begin
            if (rsp_valid && !prev_rv) begin
                if (exp_q.size() > 0) check("rsp_latency", cyc - exp_q[0].acc, exp_q[0].lat);
                else                  check("rsp_unexpected", 1, 0);
            end
            prev_rv = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rsp_id",   32'(rsp_id),   e.id);
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    check("rsp_err",  32'(rsp_err),  e.err);
                end else begin
                    check("rsp_unexpected", 1, 0);
                end
                last_data = rsp_data;
                last_id   = int'(rsp_id);
                last_err  = int'(rsp_err);
                rsp_cnt++;
            end
            if (req_ready != '0) begin
                g = -1;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    c = (exp_ptr + k) % NUM_REQ;
                    if (g < 0 && req_valid[c]) g = c;
                end
                if (g < 0) begin
                    check("grant_spurious", 32'(req_ready), 0);
                end else begin
                    check("grant", 32'(req_ready), 32'(1) << g);
                    exp_ptr = g;
                    grant_log.push_back(g);
                    grant_cnt++;
                    mop = req_op[4*g +: 4];
                    ma  = req_a[4*g +: 4];
                    mb  = req_b[4*g +: 4];
                    ne.id  = g;
                    ne.acc = cyc;
                    if (mop[3:2] == 2'b11) begin
                        ne.data = 8'h00; ne.err = 1; ne.lat = 1;
                    end else begin
                        ne.data = alu_f(mop, ma, mb, rf_exp[mb]);
                        ne.err  = 0;
                        ne.lat  = ALU_LAT + 1;
                        if (mop == OP_REG_WRITE) rf_exp[mb] = ma;
                    end
                    exp_q.push_back(ne);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input int i, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        bit got;
        got = 0;
        @(posedge clk); #1;
        req_op[4*i +: 4] = op;
        req_a[4*i +: 4]  = a;
        req_b[4*i +: 4]  = b;
        req_valid[i]     = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1;
        end
        if (!got) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsps(input int target);
        for (int k = 0; k < 200 && rsp_cnt < target; k++) @(negedge clk);
        if (rsp_cnt < target) check("rsp_timeout", rsp_cnt, target);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    int         base, r0, saved;
    logic [7:0] s_data;
    int         s_id, s_err;

    initial begin
        rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_busy",      32'(busy), 0);
        check("rst_alu_uio",   32'(alu_uio), 32'h07);
        check("rst_alu_ui_in", 32'(alu_ui_in), 0);
        check("rst_rsp_data",  32'(rsp_data), 0);
        check("rst_rsp_id",    32'(rsp_id), 0);
        check("rst_rsp_err",   32'(rsp_err), 0);
        @(posedge clk); #1 rst = 1'b0;
        rsp_ready = 1'b1;

        // ADD 3+5 -> 1000 with N and V set
        r0 = rsp_cnt;
        issue(0, OP_ADD, 4'd3, 4'd5);
        wait_rsps(r0 + 1);
        check("add_data", 32'(last_data), 32'h68);
        check("add_id",   last_id, 0);

        // Both requesters continuously valid: grants alternate 1,0,1,0
        base = grant_cnt; r0 = rsp_cnt;
        @(posedge clk); #1;
        req_op = {OP_SUB, OP_ADD}; req_a = {4'd7, 4'd1}; req_b = {4'd2, 4'd1};
        req_valid = 2'b11;
        for (int k = 0; k < 200 && grant_cnt < base + 4; k++) @(negedge clk);
        @(posedge clk); #1 req_valid = '0;
        wait_rsps(r0 + 4);
        for (int k = 0; k < 4; k++)
            if (grant_log.size() > base + k) check("alternate", grant_log[base + k], (k % 2 == 0) ? 1 : 0);
            else                             check("alternate_missing", k, 4);

        // Register file write by req1, read back by req0
        r0 = rsp_cnt;
        issue(1, OP_REG_WRITE, 4'd7, 4'd3);
        wait_rsps(r0 + 1);
        issue(0, OP_REG_READ, 4'd0, 4'd3);
        wait_rsps(r0 + 2);
        check("rdreg_data", 32'(last_data[3:0]), 7);
        check("rdreg_id",   last_id, 0);

        // Illegal opcode: error response, ALU never sees the op
        r0 = rsp_cnt;
        issue(0, 4'hC, 4'd1, 4'd2);
        repeat (3) begin
            @(negedge clk);
            check("illegal_uio", 32'(alu_uio), 32'h07);
        end
        wait_rsps(r0 + 1);
        check("illegal_err",  last_err, 1);
        check("illegal_data", 32'(last_data), 0);

        // Response back-pressure with a competing request waiting
        rsp_ready = 1'b0;
        r0 = rsp_cnt;
        issue(1, OP_SUB, 4'd9, 4'd4);
        req_op[3:0] = OP_ADD; req_a[3:0] = 4'd2; req_b[3:0] = 4'd3;
        req_valid[0] = 1'b1;
        for (int k = 0; k < 50 && !rsp_valid; k++) @(negedge clk);
        check("hold_rsp_valid", 32'(rsp_valid), 1);
        s_data = rsp_data; s_id = int'(rsp_id); s_err = int'(rsp_err);
        repeat (5) begin
            @(negedge clk);
            check("hold_valid",     32'(rsp_valid), 1);
            check("hold_data",      32'(rsp_data), 32'(s_data));
            check("hold_id",        32'(rsp_id), s_id);
            check("hold_err",       32'(rsp_err), s_err);
            check("hold_req_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bubble_busy",  32'(busy), 0);
        check("bubble_grant", 32'(req_ready), 32'h1);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        wait_rsps(r0 + 2);

        // Reset in the middle of EXEC drops the operation
        issue(0, OP_ADD, 4'd1, 4'd2);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_uio",   32'(alu_uio), 32'h07);
        check("mid_rst_valid", 32'(rsp_valid), 0);
        check("mid_rst_busy",  32'(busy), 0);
        check("mid_rst_ui_in", 32'(alu_ui_in), 0);
        exp_q.delete();
        exp_ptr = 0;
        saved = rsp_cnt;
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        check("no_rsp_after_rst", rsp_cnt, saved);

        // Pointer back to 0 after reset: with both valid, requester 1 wins
        base = grant_cnt; r0 = rsp_cnt;
        @(posedge clk); #1;
        req_op = {OP_ADD, OP_ADD}; req_a = {4'd2, 4'd4}; req_b = {4'd2, 4'd4};
        req_valid = 2'b11;
        for (int k = 0; k < 50 && grant_cnt == base; k++) @(negedge clk);
        @(posedge clk); #1 req_valid = '0;
        wait_rsps(r0 + 1);
        if (grant_log.size() > base) check("post_rst_grant", grant_log[base], 1);
        else                         check("post_rst_grant_missing", 0, 1);
        check("post_rst_data", 32'(last_data), 32'h04);

        repeat (4) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
